// File: rtl/control_fsm.sv
// control_fsm: multicycle MIPS control sequencer.
// Fetch/execute FSM with memory stalls, MULT/DIV wait and HALT.
module control_fsm #(
  parameter int MULDIV_LATENCY  = 32,
  parameter bit MEM_WAIT_EN     = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  input  logic [5:0] function_i,
  input  logic       waitrequest_i,
  input  logic       alu_zero_i,
  input  logic       jr_zero_i,
  output logic [2:0] state_o,
  output logic       active_o,
  output logic       pc_wen_o,
  output logic       ir_wen_o,
  output logic       ram_wen_o,
  output logic       ram_rds_o,
  output logic       reg_wen_o,
  output logic       src_b_sel_o,
  output logic       ram_a_sel_o,
  output logic [1:0] pc_sel_o,
  output logic [1:0] reg_a3_sel_o,
  output logic [1:0] reg_wd_sel_o,
  output logic       muldiv_start_o,
  output logic       hilo_wen_o,
  output logic       illegal_o
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC1  = 3'd1,
    EXEC2  = 3'd2,
    MULDIV = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam int CW = (MULDIV_LATENCY > 0) ?
    $clog2(MULDIV_LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    CW'((MULDIV_LATENCY > 0) ? MULDIV_LATENCY - 1 : 0);
  localparam bit MD_FAST = (MULDIV_LATENCY == 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic          e1_seen_q;

  logic r_type, is_addiu, is_addu, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_jal, is_jr;
  logic is_md, legal, stall;

  assign r_type   = opcode_i == 6'h00;
  assign is_addiu = opcode_i == 6'h09;
  assign is_lw    = opcode_i == 6'h23;
  assign is_sw    = opcode_i == 6'h2B;
  assign is_beq   = opcode_i == 6'h04;
  assign is_bne   = opcode_i == 6'h05;
  assign is_j     = opcode_i == 6'h02;
  assign is_jal   = opcode_i == 6'h03;
  assign is_addu  = r_type && function_i == 6'h21;
  assign is_jr    = r_type && function_i == 6'h08;
  // MULT/MULTU/DIV/DIVU occupy functions 0x18..0x1B
  assign is_md    = r_type &&
                    function_i[5:2] == 4'b0110;

  assign legal = is_addiu | is_addu | is_lw |
                 is_sw | is_beq | is_bne | is_j |
                 is_jal | is_jr | is_md;

  assign stall = MEM_WAIT_EN && waitrequest_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      e1_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= 1'b1;
      e1_seen_q <= (state_q == EXEC1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (run_q) begin
      unique case (state_q)
        FETCH: begin
          if (!stall) state_d = EXEC1;
        end
        EXEC1: begin
          if (!legal)
            state_d = HALT_ON_ILLEGAL ? HALT : EXEC2;
          else if (!(is_lw && stall))
            state_d = EXEC2;
        end
        EXEC2: begin
          if (!(is_sw && stall)) begin
            state_d = FETCH;
            if (is_jr && jr_zero_i) begin
              state_d = HALT;
            end else if (is_md && !MD_FAST) begin
              state_d = MULDIV;
              cnt_d   = CNT_INIT;
            end
          end
        end
        MULDIV: begin
          if (cnt_q == '0) state_d = FETCH;
          else cnt_d = cnt_q - 1'b1;
        end
        HALT: state_d = HALT;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    pc_wen_o       = 1'b0;
    ir_wen_o       = 1'b0;
    ram_wen_o      = 1'b0;
    ram_rds_o      = 1'b0;
    reg_wen_o      = 1'b0;
    src_b_sel_o    = 1'b0;
    ram_a_sel_o    = 1'b0;
    pc_sel_o       = 2'd0;
    reg_a3_sel_o   = 2'd0;
    reg_wd_sel_o   = 2'd0;
    muldiv_start_o = 1'b0;
    hilo_wen_o     = 1'b0;
    illegal_o      = 1'b0;
    if (run_q) begin
      unique case (state_q)
        FETCH: ram_rds_o = 1'b1;
        EXEC1: begin
          ir_wen_o  = !e1_seen_q;
          illegal_o = !legal;
          if (is_lw) begin
            ram_rds_o   = 1'b1;
            ram_a_sel_o = 1'b1;
            src_b_sel_o = 1'b1;
          end
        end
        EXEC2: begin
          pc_wen_o = 1'b1;
          unique case (1'b1)
            is_addiu: begin
              reg_wen_o    = 1'b1;
              reg_wd_sel_o = 2'd1;
              src_b_sel_o  = 1'b1;
            end
            is_addu: begin
              reg_wen_o    = 1'b1;
              reg_wd_sel_o = 2'd1;
              reg_a3_sel_o = 2'd1;
            end
            is_lw: reg_wen_o = 1'b1;
            is_sw: begin
              ram_wen_o   = 1'b1;
              ram_a_sel_o = 1'b1;
              src_b_sel_o = 1'b1;
              pc_wen_o    = !stall;
            end
            is_beq, is_bne: begin
              pc_sel_o = (alu_zero_i == is_beq) ?
                         2'd1 : 2'd0;
            end
            is_j: pc_sel_o = 2'd2;
            is_jal: begin
              pc_sel_o     = 2'd2;
              reg_wen_o    = 1'b1;
              reg_a3_sel_o = 2'd2;
              reg_wd_sel_o = 2'd2;
            end
            is_jr: pc_sel_o = 2'd3;
            is_md: begin
              muldiv_start_o = 1'b1;
              hilo_wen_o     = MD_FAST;
              pc_wen_o       = MD_FAST;
            end
            default: pc_sel_o = 2'd0;
          endcase
        end
        MULDIV: begin
          hilo_wen_o = (cnt_q == '0);
          pc_wen_o   = (cnt_q == '0);
        end
        HALT: pc_wen_o = 1'b0;
        default: pc_wen_o = 1'b0;
      endcase
    end
  end

  assign state_o  = state_q;
  assign active_o = run_q && (state_q != HALT);

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: vector table, directed sequences and random
// instruction streams against a per-instruction cycle model.
module tb_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       act, pcw, irw, ramw, rds, regw, srcb, rama;
    logic [1:0] pcs, a3, wd;
    logic       start, hilo, ill;
  } outs_t;

  typedef struct {
    logic  w;
    outs_t o;
  } cyc_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       az, jz;
    outs_t      e2;
    logic [2:0] nxt;
  } vec_t;

  localparam int K_ADDIU = 0, K_ADDU = 1, K_LW = 2, K_SW = 3;
  localparam int K_BEQ = 4, K_BNE = 5, K_J = 6, K_JAL = 7;
  localparam int K_JR = 8, K_MD = 9, K_ILL = 10;
  localparam int F_IRW = 0, F_RAMW = 1, F_PCW = 2, F_E1 = 3;
  localparam int F_MD = 4, F_START = 5, F_ILL = 6;
  localparam int NV = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       waitreq = 1'b0, alu_zero = 1'b0, jr_zero = 1'b0;
  bit         sel = 1'b0;
  int         checks = 0, fails = 0;
  wire [19:0] va, vb;
  outs_t      oa, ob, cur;
  outs_t      tr[16];
  cyc_t       exp_q[$];
  vec_t       tbl[NV];

  always #5 clk = ~clk;

  assign oa  = outs_t'(va);
  assign ob  = outs_t'(vb);
  assign cur = sel ? ob : oa;

  control_fsm #(
    .MULDIV_LATENCY(4), .MEM_WAIT_EN(1'b1),
    .HALT_ON_ILLEGAL(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .opcode_i(opcode), .function_i(funct),
    .waitrequest_i(waitreq), .alu_zero_i(alu_zero),
    .jr_zero_i(jr_zero),
    .state_o(va[19:17]), .active_o(va[16]),
    .pc_wen_o(va[15]), .ir_wen_o(va[14]),
    .ram_wen_o(va[13]), .ram_rds_o(va[12]),
    .reg_wen_o(va[11]), .src_b_sel_o(va[10]),
    .ram_a_sel_o(va[9]), .pc_sel_o(va[8:7]),
    .reg_a3_sel_o(va[6:5]), .reg_wd_sel_o(va[4:3]),
    .muldiv_start_o(va[2]), .hilo_wen_o(va[1]),
    .illegal_o(va[0])
  );

  control_fsm #(
    .MULDIV_LATENCY(0), .MEM_WAIT_EN(1'b0),
    .HALT_ON_ILLEGAL(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .opcode_i(opcode), .function_i(funct),
    .waitrequest_i(waitreq), .alu_zero_i(alu_zero),
    .jr_zero_i(jr_zero),
    .state_o(vb[19:17]), .active_o(vb[16]),
    .pc_wen_o(vb[15]), .ir_wen_o(vb[14]),
    .ram_wen_o(vb[13]), .ram_rds_o(vb[12]),
    .reg_wen_o(vb[11]), .src_b_sel_o(vb[10]),
    .ram_a_sel_o(vb[9]), .pc_sel_o(vb[8:7]),
    .reg_a3_sel_o(vb[6:5]), .reg_wd_sel_o(vb[4:3]),
    .muldiv_start_o(vb[2]), .hilo_wen_o(vb[1]),
    .illegal_o(vb[0])
  );

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  function automatic outs_t mk(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    o.act = 1'b1;
    return o;
  endfunction

  function automatic outs_t fo();
    outs_t o;
    o = mk(3'd0);
    o.rds = 1'b1;
    return o;
  endfunction

  function automatic outs_t ho();
    outs_t o;
    o = '0;
    o.st = 3'd4;
    return o;
  endfunction

  function automatic outs_t e2o(
    input logic pcw, regw, ramw, srcb, rama,
    input logic [1:0] pcs, a3, wd,
    input logic start);
    outs_t o;
    o = mk(3'd2);
    o.pcw = pcw; o.regw = regw; o.ramw = ramw;
    o.srcb = srcb; o.rama = rama; o.pcs = pcs;
    o.a3 = a3; o.wd = wd; o.start = start;
    return o;
  endfunction

  function automatic int cnt(input int n, input int f);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      case (f)
        F_IRW:   c += int'(tr[i].irw);
        F_RAMW:  c += int'(tr[i].ramw);
        F_PCW:   c += int'(tr[i].pcw);
        F_E1:    c += int'(tr[i].st == 3'd1);
        F_MD:    c += int'(tr[i].st == 3'd3);
        F_START: c += int'(tr[i].start);
        default: c += int'(tr[i].ill);
      endcase
    end
    return c;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got, want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic set_ins(input logic [5:0] op, fn,
                         input logic az, jz);
    opcode = op; funct = fn;
    alu_zero = az; jr_zero = jz;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    waitreq = 1'b0;
    #2 chk("async_reset", cur, 0);
    @(posedge clk); #1;
    chk("reset_hold", cur, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pre_first_clk", cur, 0);
    @(posedge clk); #1;
    chk("first_fetch", cur, fo());
  endtask

  task automatic trace(input int n, input logic [15:0] wv);
    for (int i = 0; i < n; i++) begin
      waitreq = wv[i];
      @(negedge clk);
      tr[i] = cur;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_fetch();
    for (int j = 0; j < 12 && cur.st != 3'd0; j++) begin
      @(posedge clk); #1;
    end
    chk("drain_to_fetch", cur.st, 3'd0);
  endtask

  task automatic push(input logic w, input outs_t o);
    exp_q.push_back('{w, o});
  endtask

  // Expected cycle list for one instruction
  task automatic build(input int k, wf, w1, w2, lat,
                       input logic az, jz,
                       input bit mwe, hoi,
                       output bit halted);
    outs_t o;
    int n;
    halted = 1'b0;
    n = mwe ? wf : 0;
    for (int i = 0; i <= n; i++)
      push(mwe ? (i < n) : rb(), fo());
    if (k == K_LW) begin
      n = mwe ? w1 : 0;
      for (int i = 0; i <= n; i++) begin
        o = mk(3'd1);
        o.irw = (i == 0);
        o.rds = 1'b1; o.rama = 1'b1; o.srcb = 1'b1;
        push(mwe ? (i < n) : rb(), o);
      end
    end else begin
      o = mk(3'd1);
      o.irw = 1'b1;
      o.ill = (k == K_ILL);
      push(rb(), o);
      if (k == K_ILL && hoi) begin
        push(rb(), ho()); push(rb(), ho());
        halted = 1'b1;
        return;
      end
    end
    if (k == K_SW) begin
      n = mwe ? w2 : 0;
      for (int i = 0; i <= n; i++) begin
        o = mk(3'd2);
        o.ramw = 1'b1; o.rama = 1'b1; o.srcb = 1'b1;
        o.pcw = (i == n);
        push(mwe ? (i < n) : rb(), o);
      end
      return;
    end
    o = mk(3'd2);
    o.pcw = 1'b1;
    case (k)
      K_ADDIU: begin o.regw = 1; o.wd = 1; o.srcb = 1; end
      K_ADDU:  begin o.regw = 1; o.wd = 1; o.a3 = 1; end
      K_LW:    o.regw = 1'b1;
      K_BEQ:   o.pcs = az ? 2'd1 : 2'd0;
      K_BNE:   o.pcs = az ? 2'd0 : 2'd1;
      K_J:     o.pcs = 2'd2;
      K_JAL:   begin o.pcs = 2; o.regw = 1; o.a3 = 2; o.wd = 2; end
      K_JR:    o.pcs = 2'd3;
      K_MD:    begin
        o.start = 1'b1;
        o.hilo = (lat == 0);
        o.pcw = (lat == 0);
      end
      default: ;
    endcase
    push(rb(), o);
    if (k == K_MD) begin
      for (int i = 1; i <= lat; i++) begin
        o = mk(3'd3);
        o.hilo = (i == lat);
        o.pcw = (i == lat);
        push(rb(), o);
      end
    end
    if (k == K_JR && jz) begin
      push(rb(), ho()); push(rb(), ho());
      halted = 1'b1;
    end
  endtask

  task automatic run_exp(input int t);
    cyc_t c;
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      waitreq = c.w;
      @(negedge clk);
      chk($sformatf("rand_i%0d_c%0d", t, i), cur, c.o);
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic rand_run(input int nins, lat,
                          input bit mwe, hoi);
    int k;
    bit halted;
    logic [5:0] op, fn;
    logic az, jz;
    for (int t = 0; t < nins; t++) begin
      k = $urandom_range(10);
      if (k == K_ILL && $urandom_range(3) != 0) k = K_ADDIU;
      fn = 6'($urandom_range(63));
      az = rb();
      jz = rb();
      case (k)
        K_ADDIU: op = 6'h09;
        K_ADDU:  begin op = 6'h00; fn = 6'h21; end
        K_LW:    op = 6'h23;
        K_SW:    op = 6'h2B;
        K_BEQ:   op = 6'h04;
        K_BNE:   op = 6'h05;
        K_J:     op = 6'h02;
        K_JAL:   op = 6'h03;
        K_JR: begin
          op = 6'h00; fn = 6'h08;
          jz = ($urandom_range(7) == 0);
        end
        K_MD: begin
          op = 6'h00;
          fn = 6'h18 + 6'($urandom_range(3));
        end
        default: begin
          case ($urandom_range(3))
            0: op = 6'h3F;
            1: begin op = 6'h00; fn = 6'h20; end
            2: begin op = 6'h00; fn = 6'h00; end
            default: op = 6'h08;
          endcase
        end
      endcase
      set_ins(op, fn, az, jz);
      build(k, $urandom_range(3), $urandom_range(3),
            $urandom_range(3), lat, az, jz, mwe, hoi, halted);
      run_exp(t);
      if (halted) do_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] pat;
    logic [1:0] a3_first;
    outs_t w;

    tbl[0]  = '{6'h09, 6'h00, 0, 0, e2o(1,1,0,1,0,0,0,1,0), 3'd0};
    tbl[1]  = '{6'h00, 6'h21, 0, 0, e2o(1,1,0,0,0,0,1,1,0), 3'd0};
    tbl[2]  = '{6'h23, 6'h00, 0, 0, e2o(1,1,0,0,0,0,0,0,0), 3'd0};
    tbl[3]  = '{6'h2B, 6'h00, 0, 0, e2o(1,0,1,1,1,0,0,0,0), 3'd0};
    tbl[4]  = '{6'h04, 6'h00, 1, 0, e2o(1,0,0,0,0,1,0,0,0), 3'd0};
    tbl[5]  = '{6'h04, 6'h00, 0, 0, e2o(1,0,0,0,0,0,0,0,0), 3'd0};
    tbl[6]  = '{6'h05, 6'h00, 0, 0, e2o(1,0,0,0,0,1,0,0,0), 3'd0};
    tbl[7]  = '{6'h05, 6'h00, 1, 0, e2o(1,0,0,0,0,0,0,0,0), 3'd0};
    tbl[8]  = '{6'h02, 6'h00, 0, 0, e2o(1,0,0,0,0,2,0,0,0), 3'd0};
    tbl[9]  = '{6'h03, 6'h00, 0, 0, e2o(1,1,0,0,0,2,2,2,0), 3'd0};
    tbl[10] = '{6'h00, 6'h08, 0, 0, e2o(1,0,0,0,0,3,0,0,0), 3'd0};
    tbl[11] = '{6'h00, 6'h19, 0, 0, e2o(0,0,0,0,0,0,0,0,1), 3'd3};
    tbl[12] = '{6'h00, 6'h1B, 0, 0, e2o(0,0,0,0,0,0,0,0,1), 3'd3};

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < NV; i++) begin
      set_ins(tbl[i].op, tbl[i].fn, tbl[i].az, tbl[i].jz);
      waitreq = 1'b0;
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("tbl%0d_exec2", i), cur, tbl[i].e2);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_next", i), cur.st, tbl[i].nxt);
      wait_fetch();
    end

    set_ins(6'h09, 6'h00, 0, 0);
    trace(3, '0);
    for (int i = 0; i < 3; i++) pat[i] = tr[i].regw;
    a3_first = tr[2].a3;
    set_ins(6'h00, 6'h21, 0, 0);
    trace(3, '0);
    for (int i = 0; i < 3; i++) pat[i+3] = tr[i].regw;
    chk("regw_pattern", pat, 6'b100100);
    chk("a3_addiu", a3_first, 2'd0);
    chk("a3_addu", tr[2].a3, 2'd1);
    chk("addu_states", {tr[0].st, tr[1].st, tr[2].st},
        {3'd0, 3'd1, 3'd2});

    set_ins(6'h23, 6'h00, 0, 0);
    trace(5, 16'b00110);
    chk("lw_exec1_cycles", cnt(5, F_E1), 3);
    chk("lw_irw_pulses", cnt(5, F_IRW), 1);
    chk("lw_irw_first", tr[1].irw, 1'b1);
    chk("lw_exec2_regw", {tr[4].st, tr[4].regw}, {3'd2, 1'b1});
    chk("lw_back_fetch", cur.st, 3'd0);

    set_ins(6'h2B, 6'h00, 0, 0);
    trace(6, 16'b011100);
    chk("sw_ramw_cycles", cnt(6, F_RAMW), 4);
    chk("sw_pcw_count", cnt(6, F_PCW), 1);
    chk("sw_pcw_last", tr[5].pcw, 1'b1);
    chk("sw_back_fetch", cur.st, 3'd0);

    set_ins(6'h00, 6'h18, 0, 0);
    trace(7, '0);
    chk("mult_start_cnt", cnt(7, F_START), 1);
    chk("mult_start_e2", tr[2].start, 1'b1);
    chk("mult_md_cycles", cnt(7, F_MD), 4);
    chk("mult_pcw_cnt", cnt(7, F_PCW), 1);
    chk("mult_last", {tr[6].hilo, tr[6].pcw}, 2'b11);
    chk("mult_back_fetch", cur.st, 3'd0);

    set_ins(6'h00, 6'h08, 0, 1);
    trace(4, '0);
    chk("jr_pc_write", {tr[2].pcw, tr[2].pcs}, {1'b1, 2'd3});
    chk("jr_halt", tr[3], ho());
    do_reset();

    set_ins(6'h3F, 6'h00, 0, 0);
    trace(4, '0);
    chk("ill_pulse_cnt", cnt(4, F_ILL), 1);
    chk("ill_pulse_e1", tr[1].ill, 1'b1);
    chk("ill_no_pcw", cnt(4, F_PCW), 0);
    chk("ill_halt0", tr[2], ho());
    chk("ill_halt1", tr[3], ho());
    do_reset();

    set_ins(6'h00, 6'h1A, 0, 0);
    trace(5, '0);
    chk("div_in_muldiv", tr[4].st, 3'd3);
    do_reset();

    sel = 1'b1;
    do_reset();
    set_ins(6'h3F, 6'h00, 0, 0);
    trace(3, '0);
    chk("b_ill_pulse", cnt(3, F_ILL), 1);
    chk("b_ill_nop", tr[2], e2o(1,0,0,0,0,0,0,0,0));
    chk("b_ill_fetch", cur.st, 3'd0);
    set_ins(6'h09, 6'h00, 0, 0);
    trace(3, 16'hFFFF);
    chk("b_nowait_states", {tr[0].st, tr[1].st, tr[2].st},
        {3'd0, 3'd1, 3'd2});
    set_ins(6'h00, 6'h18, 0, 0);
    trace(3, '0);
    w = e2o(1,0,0,0,0,0,0,0,1);
    w.hilo = 1'b1;
    chk("b_mult_fast", tr[2], w);
    chk("b_mult_fetch", cur.st, 3'd0);
    rand_run(120, 0, 1'b0, 1'b0);

    sel = 1'b0;
    do_reset();
    rand_run(120, 4, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             checks, fails);
    $finish;
  end

endmodule
